dp_sequencer: RTL
=================

// Module: dp_sequencer
// PURPOSE
//  Multi-cycle issue controller for the 4x32 regfile + ALU32 datapath. Accepts one
//  packed instruction per valid/ready handshake and drives ALUControl/addr1/addr2/addr3/wr
//  through DECODE->EXEC->WB. Captures Result/Zero/Overflow into status flags and
//  suppresses writeback per instruction mode. Sits between the instruction source and
//  the datapath.
// PARAMETERS
//  OPW  3   ALUControl width (passed through unmodified to datapath)
//  AW   2   register address width (4 registers)
//  DW   32  datapath Result width
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  instr_valid  in   1        instr holds a valid instruction
//  instr        in   OPW+3*AW+2  {mode[1:0], op[OPW-1:0], ra[AW-1:0], rb[AW-1:0], rd[AW-1:0]}
//  instr_ready  out  1        sequencer can accept instr this cycle
//  clr_flags    in   1        synchronous clear of sticky flags
//  Result       in   DW       datapath ALU result
//  Zero         in   1        datapath zero flag
//  Overflow     in   1        datapath overflow flag
//  ALUControl   out  OPW      to datapath
//  addr1        out  AW       source A (= ra)
//  addr2        out  AW       source B (= rb)
//  addr3        out  AW       destination (= rd)
//  wr           out  1        regfile write enable
//  busy         out  1        state != IDLE
//  done         out  1        1-cycle pulse: instruction retired
//  result_q     out  DW       Result sampled in EXEC
//  zero_q       out  1        Zero sampled in EXEC of last instruction
//  ovf_sticky   out  1        OR of Overflow over all EXECs since clear
//  illegal      out  1        sticky: mode 2'b11 seen
// BEHAVIOUR
//  - All outputs registered. Async reset (rst=0): state=IDLE, ALUControl/addr*/result_q = 0,
//    wr=busy=done=zero_q=ovf_sticky=illegal=0, instr_ready=1.
//  - Reset mid-instruction: wr drops immediately (async); the instruction is abandoned and
//    no write is issued after rst rises.
//  - FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
//    IDLE: instr_ready=1; on instr_valid&&instr_ready at posedge, latch fields -> DECODE.
//    DECODE: drive op/ra/rb/rd; wr=0 (one cycle for the combinational path to settle).
//    EXEC: sample Result->result_q, Zero->zero_q; ovf_sticky |= Overflow; compute wr_en.
//    WB: wr=wr_en for exactly one cycle with addr* and ALUControl held stable; the regfile
//    commits at the posedge ending WB.
//    Exit of WB: done=1 for one cycle (coincides with return to IDLE, instr_ready=1).
//  - instr_ready is 0 in DECODE/EXEC/WB. Latency is 4 cycles accept->done.
//    Back-to-back throughput is 1 instr/4 cycles; a new instr may be accepted in the
//    same cycle done=1.
//  - mode: 00 = write always. 01 = write only if Overflow=0 at EXEC.
//    10 = compare (flags only, wr=0). 11 = as 10 plus set illegal.
//  - addr*/ALUControl hold their last values in IDLE (no X-toggling).
//  - ra/rb may equal rd: the read is completed in EXEC; the write lands after WB.
//  - clr_flags clears ovf_sticky and illegal at posedge. If it coincides with a set in the
//    same cycle, the set wins.
//  - instr_valid while busy: ignored; the source must hold it until instr_ready.
// TESTING
//  1 rst=0 at t=0, release: all outputs = reset values, instr_ready=1, wr never glitches high.
//  2 R2=F0F0F0F0, R3=0FF00FF0, instr{00,010,ra=2,rb=3,rd=1}:
//    wr=1 exactly in cycle 3, done at cycle 4, R1=00F000F0, result_q=00F000F0, zero_q=0.
//  3 mode 01, datapath model forces Overflow=1 in EXEC:
//    wr stays 0, R-dest unchanged, ovf_sticky=1. Then clr_flags -> ovf_sticky=0.
//  4 mode 10 with R2 AND R3 where the operands are disjoint (Result=0):
//    zero_q=1, wr=0, done pulses. Mode 11 -> illegal=1, no write.
//  5 instr_valid held high with 3 queued instrs: accepts at cycles 0, 4 and 8 only;
//    three done pulses; instr_ready=0 in between.
//  6 rst=0 asserted during WB: wr falls within the cycle, state=IDLE, dest register not
//    written, the next instruction executes normally.

Source files
------------

// File: rtl/dp_sequencer.sv
// ---------------------------------------------------------------------------
// dp_sequencer
//   Multi-cycle issue controller for the 4x32 register file + ALU32 datapath.
//   It accepts one packed instruction per valid/ready handshake, then walks
//   it through DECODE -> EXEC -> WB. The datapath result and flags are
//   captured in EXEC. The register-file write strobe is raised only in WB,
//   and only when the instruction mode allows the write.
//
//   Instruction layout (MSB..LSB): {mode[1:0], op[OPW-1:0], ra, rb, rd}
//     mode 00 : always write rd
//     mode 01 : write rd only if Overflow is low in EXEC
//     mode 10 : compare, flags only
//     mode 11 : compare, flags only, and set the sticky illegal flag
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   instr_valid/instr instruction handshake from the source
//   instr_ready       sequencer is idle and can take an instruction
//   clr_flags         synchronous clear of ovf_sticky / illegal
//   Result/Zero/Overflow  datapath ALU outputs
//   ALUControl, addr1/2/3, wr  datapath controls (all registered)
//   busy, done        status: not idle / one-cycle retire pulse
//   result_q, zero_q  Result / Zero captured in EXEC
//   ovf_sticky        OR of Overflow over every EXEC since the last clear
//   illegal           sticky: a mode-11 instruction was executed
// ---------------------------------------------------------------------------
module dp_sequencer #(
  parameter int OPW = 3,
  parameter int AW  = 2,
  parameter int DW  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [OPW+3*AW+1:0]    instr,
  output logic                   instr_ready,
  input  logic                   clr_flags,
  input  logic [DW-1:0]          Result,
  input  logic                   Zero,
  input  logic                   Overflow,
  output logic [OPW-1:0]         ALUControl,
  output logic [AW-1:0]          addr1,
  output logic [AW-1:0]          addr2,
  output logic [AW-1:0]          addr3,
  output logic                   wr,
  output logic                   busy,
  output logic                   done,
  output logic [DW-1:0]          result_q,
  output logic                   zero_q,
  output logic                   ovf_sticky,
  output logic                   illegal
);

  localparam int IW = OPW + 3*AW + 2;

  localparam logic [1:0] MODE_ALWAYS = 2'b00;
  localparam logic [1:0] MODE_NOOVF  = 2'b01;
  localparam logic [1:0] MODE_CMP    = 2'b10;
  localparam logic [1:0] MODE_ILL    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;

  // Decoded instruction fields (combinational slices of the input bus)
  logic [1:0]       in_mode_s;
  logic [OPW-1:0]   in_op_s;
  logic [AW-1:0]    in_ra_s;
  logic [AW-1:0]    in_rb_s;
  logic [AW-1:0]    in_rd_s;

  logic             accept_s;
  logic             wr_en_s;
  logic             ovf_set_s;
  logic             ill_set_s;

  // Registered outputs and latched state
  logic [1:0]       mode_r;
  logic [OPW-1:0]   alu_ctl_r;
  logic [AW-1:0]    addr1_r;
  logic [AW-1:0]    addr2_r;
  logic [AW-1:0]    addr3_r;
  logic             wr_r;
  logic             busy_r;
  logic             done_r;
  logic             ready_r;
  logic [DW-1:0]    result_r;
  logic             zero_r;
  logic             ovf_r;
  logic             ill_r;

  assign in_mode_s = instr[IW-1 -: 2];
  assign in_op_s   = instr[3*AW +: OPW];
  assign in_ra_s   = instr[2*AW +: AW];
  assign in_rb_s   = instr[AW +: AW];
  assign in_rd_s   = instr[0 +: AW];

  assign instr_ready = ready_r;
  assign ALUControl  = alu_ctl_r;
  assign addr1       = addr1_r;
  assign addr2       = addr2_r;
  assign addr3       = addr3_r;
  assign wr          = wr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign result_q    = result_r;
  assign zero_q      = zero_r;
  assign ovf_sticky  = ovf_r;
  assign illegal     = ill_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic, handshake acceptance and write-enable decision
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    wr_en_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid && ready_r) begin
          accept_s     = 1'b1;
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        next_state_s = ST_EXEC;
      end
      ST_EXEC: begin
        next_state_s = ST_WB;
        case (mode_r)
          MODE_ALWAYS: wr_en_s = 1'b1;
          MODE_NOOVF:  wr_en_s = ~Overflow;
          MODE_CMP:    wr_en_s = 1'b0;
          MODE_ILL:    wr_en_s = 1'b0;
          default:     wr_en_s = 1'b0;
        endcase
      end
      ST_WB: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Sticky-flag set conditions, evaluated while the instruction is in EXEC
  always_comb begin
    ovf_set_s = 1'b0;
    ill_set_s = 1'b0;
    if (state_r == ST_EXEC) begin
      ovf_set_s = Overflow;
      ill_set_s = (mode_r == MODE_ILL);
    end else begin
      ovf_set_s = 1'b0;
      ill_set_s = 1'b0;
    end
  end

  // Datapath control fields: loaded on accept, held otherwise so the
  // datapath sees stable addresses through DECODE/EXEC/WB and in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r    <= 2'b00;
      alu_ctl_r <= {OPW{1'b0}};
      addr1_r   <= {AW{1'b0}};
      addr2_r   <= {AW{1'b0}};
      addr3_r   <= {AW{1'b0}};
    end else if (accept_s) begin
      mode_r    <= in_mode_s;
      alu_ctl_r <= in_op_s;
      addr1_r   <= in_ra_s;
      addr2_r   <= in_rb_s;
      addr3_r   <= in_rd_s;
    end
  end

  // Handshake / status outputs derived from the next state so they line
  // up with the state they describe. The write strobe is asserted only in
  // WB; the async reset drops it immediately if a reset lands mid-WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      ready_r <= (next_state_s == ST_IDLE);
      busy_r  <= (next_state_s != ST_IDLE);
      done_r  <= (state_r == ST_WB);
      wr_r    <= (state_r == ST_EXEC) && wr_en_s;
    end
  end

  // Result / Zero capture at the end of EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {DW{1'b0}};
      zero_r   <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      result_r <= Result;
      zero_r   <= Zero;
    end
  end

  // Sticky flags: a set in the same cycle as clr_flags takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      ill_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_flags) begin
        ovf_r <= 1'b0;
      end
      if (ill_set_s) begin
        ill_r <= 1'b1;
      end else if (clr_flags) begin
        ill_r <= 1'b0;
      end
    end
  end

endmodule
